// File: rtl/frame_buffer_scheduler_pkg.sv
// Shared types and constants for the ping-pong frame buffer scheduler:
// consumer FSM encoding, register word addresses and register bit positions.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_START = 2'd1,
    CS_BUSY  = 2'd2
  } cons_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_FRAME  = 2'd2;
  localparam logic [1:0] ADDR_DROP   = 2'd3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_ERR_CLR = 2;

  localparam int ST_SW0        = 0;
  localparam int ST_SW1        = 1;
  localparam int ST_FULL_LO    = 2;
  localparam int ST_STATE_LO   = 4;
  localparam int ST_PROD_READY = 6;
  localparam int ST_ERR        = 7;

  function automatic logic [31:0] pack_status(input logic       sw0,
                                              input logic       sw1,
                                              input logic [1:0] full,
                                              input logic [1:0] state,
                                              input logic       prod_ready,
                                              input logic       err);
    logic [31:0] st;
    st                      = '0;
    st[ST_SW0]              = sw0;
    st[ST_SW1]              = sw1;
    st[ST_FULL_LO +: 2]     = full;
    st[ST_STATE_LO +: 2]    = state;
    st[ST_PROD_READY]       = prod_ready;
    st[ST_ERR]              = err;
    return st;
  endfunction

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Avalon-MM slave bus between the Nios/WiFi host and the frame buffer scheduler.
interface frame_buffer_scheduler_if;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;

   modport master (output address, write, writedata, read, input readdata);
   modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/frame_buffer_scheduler_regs.sv
// Host register block: address decode, CTRL enable, write-one strobes,
// saturating frame/drop counters and the registered read-data mux.
module frame_sched_regs
   import frame_sched_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                    csi_clk,
   input  logic                    rsi_reset,
   frame_buffer_scheduler_if.slave avs,
   input  logic [31:0]             status_word,
   input  logic                    frame_inc,
   input  logic                    drop_inc,
   output logic                    enable,
   output logic                    flush,
   output logic                    err_clear
);

   logic             ctrl_wr;
   logic             frame_clr;
   logic             drop_clr;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   assign ctrl_wr      = avs.write && (avs.address == ADDR_CTRL);
   assign frame_clr    = avs.write && (avs.address == ADDR_FRAME);
   assign drop_clr     = avs.write && (avs.address == ADDR_DROP);
   assign flush        = ctrl_wr & avs.writedata[CTRL_FLUSH];
   assign err_clear    = ctrl_wr & avs.writedata[CTRL_ERR_CLR];
   assign unused_wdata = ^avs.writedata[31:3];

   // NOTE: default every always_comb output up front so no path leaves it unassigned (no latch).
   always_comb begin
      rd_mux = '0;
      case (avs.address)
         ADDR_CTRL:   rd_mux[CTRL_ENABLE] = enable;
         ADDR_STATUS: rd_mux = status_word;
         ADDR_FRAME:  rd_mux = 32'(frame_cnt);
         ADDR_DROP:   rd_mux = 32'(drop_cnt);
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         enable       <= 1'b0;
         frame_cnt    <= '0;
         drop_cnt     <= '0;
         avs.readdata <= '0;
      end else begin
         if (ctrl_wr) enable <= avs.writedata[CTRL_ENABLE];

         // Write-clear beats a coincident increment; counters stick at all-ones.
         if (frame_clr)                        frame_cnt <= '0;
         else if (frame_inc && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;

         if (drop_clr)                         drop_cnt <= '0;
         else if (drop_inc && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;

         if (avs.read) avs.readdata <= rd_mux;
      end
   end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong scheduler for the two frame buffers feeding the DCT engine:
// buffer selects, producer/consumer handshakes, consumer watchdog.
module frame_buffer_scheduler
   import frame_sched_pkg::*;
#(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int TO_W           = 20
) (
   input  logic                    csi_clk,
   input  logic                    rsi_reset,
   frame_buffer_scheduler_if.slave avs_s0,
   output logic                    coe_c0_SW0,
   output logic                    coe_c0_SW1,
   output logic                    coe_prod_ready,
   input  logic                    coe_prod_done,
   output logic                    coe_cons_start,
   input  logic                    coe_cons_done
);

   localparam logic [1:0] C_IDLE  = CS_IDLE;
   localparam logic [1:0] C_START = CS_START;
   localparam logic [1:0] C_BUSY  = CS_BUSY;

   logic [1:0]      full, full_next;
   logic            wbuf, rbuf, err;
   logic [1:0]      state;
   logic [TO_W-1:0] wd, wd_inc;
   logic            enable, flush, err_clear;
   logic            busy, timeout, prod_accept, drop_inc, frame_inc, buf_release;

   assign coe_c0_SW0     = wbuf;
   assign coe_c0_SW1     = rbuf;
   assign coe_prod_ready = enable & ~full[wbuf];

   // Flush discards any same-cycle producer/consumer event, including its count.
   assign busy        = (state == C_BUSY);
   assign wd_inc      = wd + 1'b1;
   assign timeout     = (TIMEOUT_CYCLES != 0) && busy && !coe_cons_done &&
                        (wd_inc == TO_W'(TIMEOUT_CYCLES)) && !flush;
   assign prod_accept = coe_prod_done &  coe_prod_ready & ~flush;
   assign drop_inc    = coe_prod_done & ~coe_prod_ready & ~flush;
   assign frame_inc   = busy & coe_cons_done & ~flush;
   assign buf_release = frame_inc | timeout;

   always_comb begin
      full_next = full;
      if (prod_accept) full_next[wbuf] = 1'b1;
      if (buf_release) full_next[rbuf] = 1'b0;
   end

   always_ff @(posedge csi_clk) begin
      if (rsi_reset) begin
         full           <= '0;
         wbuf           <= 1'b0;
         rbuf           <= 1'b0;
         state          <= C_IDLE;
         wd             <= '0;
         err            <= 1'b0;
         coe_cons_start <= 1'b0;
      end else begin
         err            <= (err & ~err_clear) | timeout;
         coe_cons_start <= 1'b0;
         if (flush) begin
            full  <= '0;
            wbuf  <= 1'b0;
            rbuf  <= 1'b0;
            state <= C_IDLE;
            wd    <= '0;
         end else begin
            full <= full_next;
            if (prod_accept) wbuf <= ~wbuf;
            if (buf_release) rbuf <= ~rbuf;
            case (state)
               C_IDLE: if (enable && full[rbuf]) begin
                  state          <= C_START;
                  coe_cons_start <= 1'b1;
               end
               C_START: begin
                  state <= C_BUSY;
                  wd    <= '0;
               end
               C_BUSY: begin
                  if (buf_release) state <= C_IDLE;
                  else             wd    <= wd_inc;
               end
               default: state <= C_IDLE;
            endcase
         end
      end
   end

   frame_sched_regs #(.CNT_W(CNT_W)) u_regs (
      .csi_clk     (csi_clk),
      .rsi_reset   (rsi_reset),
      .avs         (avs_s0),
      .status_word (pack_status(wbuf, rbuf, full, state, coe_prod_ready, err)),
      .frame_inc   (frame_inc),
      .drop_inc    (drop_inc),
      .enable      (enable),
      .flush       (flush),
      .err_clear   (err_clear)
   );

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler with CNT_W=4 and an 8-cycle watchdog;
// expected values are hand-derived cycle by cycle.
module tb_frame_buffer_scheduler;
   import frame_sched_pkg::*;

   logic        csi_clk = 1'b0;
   logic        rsi_reset;
   logic        sw0, sw1, prod_ready, prod_done, cons_start, cons_done;
   logic [31:0] rd;
   int          n_checks = 0;
   int          n_errors = 0;

   frame_buffer_scheduler_if avs ();

   frame_buffer_scheduler #(.CNT_W(4), .TIMEOUT_CYCLES(8), .TO_W(20)) dut (
      .csi_clk        (csi_clk),
      .rsi_reset      (rsi_reset),
      .avs_s0         (avs),
      .coe_c0_SW0     (sw0),
      .coe_c0_SW1     (sw1),
      .coe_prod_ready (prod_ready),
      .coe_prod_done  (prod_done),
      .coe_cons_start (cons_start),
      .coe_cons_done  (cons_done)
   );

   always #5 csi_clk = ~csi_clk;

   task automatic tick();
      @(posedge csi_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      avs.address   = a;
      avs.writedata = d;
      avs.write     = 1'b1;
      tick();
      avs.write     = 1'b0;
      avs.writedata = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      avs.address = a;
      avs.read    = 1'b1;
      tick();
      avs.read    = 1'b0;
      d           = avs.readdata;
   endtask

   initial begin
      avs.address = '0; avs.write = 1'b0; avs.writedata = '0; avs.read = 1'b0;
      prod_done = 1'b0; cons_done = 1'b0;
      rsi_reset = 1'b1;
      tick(); tick();
      rsi_reset = 1'b0;

      check("reset_sw0", 32'(sw0), 32'd0);
      check("reset_sw1", 32'(sw1), 32'd0);
      check("reset_prod_ready", 32'(prod_ready), 32'd0);
      check("reset_cons_start", 32'(cons_start), 32'd0);
      check("reset_readdata", avs.readdata, 32'd0);

      // Single frame through both buffers sides
      bus_write(ADDR_CTRL, 32'h1);
      check("en_prod_ready", 32'(prod_ready), 32'd1);
      prod_done = 1'b1; tick(); prod_done = 1'b0;
      check("t1_sw0_toggle", 32'(sw0), 32'd1);
      check("t1_start_early", 32'(cons_start), 32'd0);
      tick();
      check("t1_start_pulse", 32'(cons_start), 32'd1);
      check("t1_sw1", 32'(sw1), 32'd0);
      tick();
      check("t1_start_one_cycle", 32'(cons_start), 32'd0);
      cons_done = 1'b1; tick(); cons_done = 1'b0;
      check("t1_sw1_toggle", 32'(sw1), 32'd1);
      bus_read(ADDR_STATUS, rd);
      check("t1_status", rd, 32'h43);
      bus_read(ADDR_FRAME, rd);
      check("t1_frame_cnt", rd, 32'd1);
      tick();
      check("t1_readdata_hold", avs.readdata, 32'd1);

      // Three back-to-back producer frames, no consumer completion
      prod_done = 1'b1;
      tick(); tick();
      check("t2_both_full_ready", 32'(prod_ready), 32'd0);
      tick();
      prod_done = 1'b0;
      check("t2_drop_sw0_kept", 32'(sw0), 32'd1);
      bus_read(ADDR_DROP, rd);
      check("t2_drop_cnt", rd, 32'd1);
      bus_read(ADDR_STATUS, rd);
      check("t2_status_full_busy", rd, 32'h2F);

      // Simultaneous producer and consumer completion
      cons_done = 1'b1; tick(); cons_done = 1'b0;
      check("t3_sw1_release", 32'(sw1), 32'd0);
      tick();
      check("t3_start_buf0", 32'(cons_start), 32'd1);
      tick();
      prod_done = 1'b1; cons_done = 1'b1; tick(); prod_done = 1'b0; cons_done = 1'b0;
      check("t3_sw0", 32'(sw0), 32'd0);
      check("t3_sw1", 32'(sw1), 32'd1);
      check("t3_no_start_yet", 32'(cons_start), 32'd0);
      tick();
      check("t3_start_2cyc", 32'(cons_start), 32'd1);
      bus_read(ADDR_STATUS, rd);
      check("t3_status", rd, 32'h5A);

      // Watchdog: consumer never completes
      repeat (7) tick();
      bus_read(ADDR_STATUS, rd);
      check("t4_busy_7_cycles", rd, 32'h6A);
      bus_read(ADDR_STATUS, rd);
      check("t4_timeout_status", rd, 32'hC0);
      bus_read(ADDR_FRAME, rd);
      check("t4_frame_unchanged", rd, 32'd3);
      bus_write(ADDR_CTRL, 32'h5);
      bus_read(ADDR_STATUS, rd);
      check("t4_err_cleared", rd, 32'h40);

      // Flush while busy with both buffers full, plus discarded events
      prod_done = 1'b1; tick(); tick(); prod_done = 1'b0;
      check("t5_full_ready", 32'(prod_ready), 32'd0);
      tick();
      bus_read(ADDR_STATUS, rd);
      check("t5_status_pre_flush", rd, 32'h2C);
      prod_done = 1'b1; cons_done = 1'b1;
      bus_write(ADDR_CTRL, 32'h3);
      prod_done = 1'b0; cons_done = 1'b0;
      check("t5_sw0", 32'(sw0), 32'd0);
      check("t5_sw1", 32'(sw1), 32'd0);
      check("t5_no_start", 32'(cons_start), 32'd0);
      tick();
      check("t5_no_start_later", 32'(cons_start), 32'd0);
      bus_read(ADDR_STATUS, rd);
      check("t5_status_post_flush", rd, 32'h40);
      bus_read(ADDR_FRAME, rd);
      check("t5_frame_kept", rd, 32'd3);
      bus_read(ADDR_DROP, rd);
      check("t5_drop_kept", rd, 32'd1);
      bus_read(ADDR_CTRL, rd);
      check("t5_ctrl_readback", rd, 32'd1);

      // Saturation of the 4-bit frame counter: 3 + 13 frames
      for (int i = 0; i < 13; i++) begin
         prod_done = 1'b1; tick(); prod_done = 1'b0;
         tick(); tick();
         cons_done = 1'b1; tick(); cons_done = 1'b0;
      end
      bus_read(ADDR_FRAME, rd);
      check("t6_frame_saturated", rd, 32'hF);

      // Write-clear coincident with a completing frame
      prod_done = 1'b1; tick(); prod_done = 1'b0;
      tick(); tick();
      cons_done = 1'b1;
      bus_write(ADDR_FRAME, 32'h0);
      cons_done = 1'b0;
      check("t6_release_sw1", 32'(sw1), 32'd0);
      bus_read(ADDR_FRAME, rd);
      check("t6_clear_wins", rd, 32'd0);
      bus_write(ADDR_DROP, 32'hFFFF_FFFF);
      bus_read(ADDR_DROP, rd);
      check("t6_drop_clear", rd, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
